// File: rtl/hero_anim_sequencer_if.sv
// Purpose : bundles the per-frame control, per-pixel scan and sprite-fetch signals of the hero sequencer.
// Latency : n/a (wiring only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
// Ports   : frame_tick/run_req/dir_left/hero_x/hero_y (game control), DrawX/DrawY/blank (VGA scan),
//           rom_address/sprite_hit/frame_sel/running (sprite fetch results).
interface hero_anim_sequencer_if;
  logic        frame_tick;
  logic        run_req;
  logic        dir_left;
  logic [9:0]  hero_x;
  logic [9:0]  hero_y;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic [13:0] rom_address;
  logic        sprite_hit;
  logic [2:0]  frame_sel;
  logic        running;

  // Driver side (game logic / VGA controller / bench).
  modport master (
    output frame_tick, run_req, dir_left, hero_x, hero_y, DrawX, DrawY, blank,
    input  rom_address, sprite_hit, frame_sel, running
  );

  // Sequencer side.
  modport slave (
    input  frame_tick, run_req, dir_left, hero_x, hero_y, DrawX, DrawY, blank,
    output rom_address, sprite_hit, frame_sel, running
  );
endinterface

// File: rtl/hero_anim_sequencer.sv
// Purpose : steps the hero run animation once per video frame and maps each scanned pixel to a sprite ROM address.
// Latency : rom_address/sprite_hit 1 cycle after DrawX/DrawY; animation state and position update on frame_tick.
// Backpressure: none; a new pixel is accepted every cycle.
// Ports   : vga_clk (sole clock), reset (synchronous, active-high), bus (hero_anim_sequencer_if.slave).
module hero_anim_sequencer #(
  parameter int SPRITE_W   = 40,
  parameter int SPRITE_H   = 66,
  parameter int NUM_FRAMES = 6,
  parameter int FRAME_HOLD = 5
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  hero_anim_sequencer_if.slave   bus
);

  // Hold counter only needs to reach FRAME_HOLD-1.
  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [2:0]        LAST_FRAME  = 3'(NUM_FRAMES - 1);
  localparam logic [13:0]       FRAME_WORDS = 14'(SPRITE_W * SPRITE_H);
  localparam logic [13:0]       ROW_WORDS   = 14'(SPRITE_W);
  localparam logic [13:0]       COL_LAST    = 14'(SPRITE_W - 1);
  localparam logic signed [10:0] W_S        = 11'(SPRITE_W);
  localparam logic signed [10:0] H_S        = 11'(SPRITE_H);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         frame_sel_q, frame_sel_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [9:0]         hx_q, hx_d;
  logic [9:0]         hy_q, hy_d;
  logic [13:0]        rom_address_q, rom_address_d;
  logic               sprite_hit_q, sprite_hit_d;

  // Pixel-path intermediates.
  logic signed [10:0] lx;
  logic signed [10:0] ly;
  logic               hit;
  logic [13:0]        col;
  logic [13:0]        addr;

  // ---------------------------------------------------------------------------
  // Animation FSM and position latch: everything here moves only on frame_tick,
  // so the sprite cannot tear or change pose in the middle of a displayed frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    frame_sel_d = frame_sel_q;
    hold_cnt_d  = hold_cnt_q;
    hx_d        = hx_q;
    hy_d        = hy_q;

    if (bus.frame_tick) begin
      hx_d = bus.hero_x;
      hy_d = bus.hero_y;

      case (state_q)
        IDLE: begin
          if (bus.run_req) begin
            // Frame 0 is the standing pose, so running starts at frame 1.
            state_d     = RUN;
            frame_sel_d = 3'd1;
            hold_cnt_d  = '0;
          end
        end

        RUN: begin
          if (!bus.run_req) begin
            state_d     = IDLE;
            frame_sel_d = 3'd0;
            hold_cnt_d  = '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            // Run cycle loops over frames 1..NUM_FRAMES-1, skipping the standing pose.
            if (frame_sel_q == LAST_FRAME) begin
              frame_sel_d = 3'd1;
            end else begin
              frame_sel_d = frame_sel_q + 3'd1;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end

        default: begin
          state_d     = IDLE;
          frame_sel_d = 3'd0;
          hold_cnt_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel path. Offsets are taken at 11-bit signed width so a sprite hanging
  // off the right/bottom edge produces large positive offsets and pixels left
  // of/above it produce negative ones -- both fall outside the box and are
  // clipped instead of wrapping around to the other side of the screen.
  // ---------------------------------------------------------------------------
  always_comb begin
    lx = $signed({1'b0, bus.DrawX}) - $signed({1'b0, hx_q});
    ly = $signed({1'b0, bus.DrawY}) - $signed({1'b0, hy_q});

    hit = bus.blank
        && (lx >= 11'sd0) && (lx < W_S)
        && (ly >= 11'sd0) && (ly < H_S);

    // Mirroring is per pixel so a direction change takes effect immediately.
    if (bus.dir_left) begin
      col = COL_LAST - 14'(lx[9:0]);
    end else begin
      col = 14'(lx[9:0]);
    end

    // Largest result is (NUM_FRAMES-1)*W*H + (H-1)*W + (W-1), which fits 14 bits
    // for the default geometry.
    addr = 14'(frame_sel_q) * FRAME_WORDS + 14'(ly[9:0]) * ROW_WORDS + col;

    sprite_hit_d  = hit;
    rom_address_d = hit ? addr : 14'd0;
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset wins over a coincident frame_tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_sel_q   <= 3'd0;
      hold_cnt_q    <= '0;
      hx_q          <= 10'd0;
      hy_q          <= 10'd0;
      rom_address_q <= 14'd0;
      sprite_hit_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_sel_q   <= frame_sel_d;
      hold_cnt_q    <= hold_cnt_d;
      hx_q          <= hx_d;
      hy_q          <= hy_d;
      rom_address_q <= rom_address_d;
      sprite_hit_q  <= sprite_hit_d;
    end
  end

  assign bus.rom_address = rom_address_q;
  assign bus.sprite_hit  = sprite_hit_q;
  assign bus.frame_sel   = frame_sel_q;
  assign bus.running     = (state_q == RUN);

endmodule

// File: tb/tb_hero_anim_sequencer.sv
module tb_hero_anim_sequencer;

  localparam int W  = 40;
  localparam int H  = 66;
  localparam int NF = 6;
  localparam int FH = 5;

  logic clk;
  logic reset;

  int checks;
  int errors;

  hero_anim_sequencer_if vif ();

  hero_anim_sequencer #(
    .SPRITE_W   (W),
    .SPRITE_H   (H),
    .NUM_FRAMES (NF),
    .FRAME_HOLD (FH)
  ) dut (
    .vga_clk (clk),
    .reset   (reset),
    .bus     (vif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The animation is described by the number of frame_ticks
  // spent running: pose = 1 + ((ticks-1)/FH) mod (NF-1), 0 when not running.
  // ---------------------------------------------------------------------------
  int m_run_ticks;
  int m_hx;
  int m_hy;
  int exp_addr;
  int exp_hit;
  bit m_valid;

  function automatic int model_frame(input int t);
    if (t == 0) return 0;
    return 1 + ((t - 1) / FH) % (NF - 1);
  endfunction

  always @(posedge clk) begin
    int lx;
    int ly;
    int col;
    if (reset) begin
      m_run_ticks = 0;
      m_hx        = 0;
      m_hy        = 0;
      exp_addr    = 0;
      exp_hit     = 0;
      m_valid     = 1'b1;
    end else if (m_valid) begin
      lx = int'(vif.DrawX) - m_hx;
      ly = int'(vif.DrawY) - m_hy;
      if (vif.blank && lx >= 0 && lx < W && ly >= 0 && ly < H) begin
        col      = vif.dir_left ? (W - 1 - lx) : lx;
        exp_hit  = 1;
        exp_addr = model_frame(m_run_ticks) * W * H + ly * W + col;
      end else begin
        exp_hit  = 0;
        exp_addr = 0;
      end
      if (vif.frame_tick) begin
        m_hx        = int'(vif.hero_x);
        m_hy        = int'(vif.hero_y);
        m_run_ticks = vif.run_req ? m_run_ticks + 1 : 0;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_rom_address", int'(vif.rom_address), exp_addr);
      chk("cyc_sprite_hit",  int'(vif.sprite_hit),  exp_hit);
      chk("cyc_frame_sel",   int'(vif.frame_sel),   model_frame(m_run_ticks));
      chk("cyc_running",     int'(vif.running),     (m_run_ticks > 0) ? 1 : 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change 2 time units after each rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_tick();
    vif.frame_tick = 1'b1;
    step();
    vif.frame_tick = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b, input logic d);
    vif.DrawX    = x;
    vif.DrawY    = y;
    vif.blank    = b;
    vif.dir_left = d;
    step();
  endtask

  // Hand-computed frame_sel after each of 26 consecutive running ticks.
  int exp_fs [26] = '{1, 1, 1, 1, 1,
                      2, 2, 2, 2, 2,
                      3, 3, 3, 3, 3,
                      4, 4, 4, 4, 4,
                      5, 5, 5, 5, 5,
                      1};

  initial begin
    checks  = 0;
    errors  = 0;
    m_valid = 1'b0;

    reset          = 1'b1;
    vif.frame_tick = 1'b0;
    vif.run_req    = 1'b0;
    vif.dir_left   = 1'b0;
    vif.hero_x     = 10'd0;
    vif.hero_y     = 10'd0;
    vif.DrawX      = 10'd0;
    vif.DrawY      = 10'd0;
    vif.blank      = 1'b0;

    step(); step(); step();
    chk("reset_rom_address", int'(vif.rom_address), 0);
    chk("reset_sprite_hit",  int'(vif.sprite_hit),  0);
    chk("reset_frame_sel",   int'(vif.frame_sel),   0);
    chk("reset_running",     int'(vif.running),     0);
    reset = 1'b0;
    step();

    // run_req without frame_tick changes nothing.
    vif.run_req = 1'b1;
    step(); step(); step();
    chk("no_tick_running",   int'(vif.running),   0);
    chk("no_tick_frame_sel", int'(vif.frame_sel), 0);
    vif.run_req = 1'b0;

    // Latch position (100,200).
    vif.hero_x = 10'd100;
    vif.hero_y = 10'd200;
    do_tick();

    pix(10'd100, 10'd200, 1'b1, 1'b0);
    chk("origin_addr", int'(vif.rom_address), 0);
    chk("origin_hit",  int'(vif.sprite_hit),  1);

    pix(10'd100, 10'd201, 1'b1, 1'b1);
    chk("mirror_addr", int'(vif.rom_address), 79);

    pix(10'd139, 10'd265, 1'b1, 1'b0);
    chk("last_px_addr", int'(vif.rom_address), 2639);
    chk("last_px_hit",  int'(vif.sprite_hit),  1);

    pix(10'd140, 10'd265, 1'b1, 1'b0);
    chk("right_out_hit",  int'(vif.sprite_hit),  0);
    chk("right_out_addr", int'(vif.rom_address), 0);

    pix(10'd139, 10'd266, 1'b1, 1'b0);
    chk("below_out_hit", int'(vif.sprite_hit), 0);

    pix(10'd99, 10'd200, 1'b1, 1'b0);
    chk("left_out_hit", int'(vif.sprite_hit), 0);

    pix(10'd120, 10'd230, 1'b0, 1'b0);
    chk("blank_low_hit", int'(vif.sprite_hit), 0);

    // Mid-frame position change must not move the sprite.
    vif.hero_x = 10'd300;
    pix(10'd100, 10'd200, 1'b1, 1'b0);
    chk("midframe_hit",  int'(vif.sprite_hit),  1);
    chk("midframe_addr", int'(vif.rom_address), 0);
    vif.hero_x = 10'd100;

    // Run animation for 26 ticks.
    vif.run_req = 1'b1;
    for (int k = 0; k < 26; k++) begin
      do_tick();
      chk("run_frame_sel", int'(vif.frame_sel), exp_fs[k]);
      chk("run_running",   int'(vif.running),   1);
      if (k == 5) begin
        pix(10'd100, 10'd200, 1'b1, 1'b0);
        chk("frame2_addr", int'(vif.rom_address), 5280);
      end
      if (k == 20) begin
        pix(10'd139, 10'd265, 1'b1, 1'b0);
        chk("max_addr", int'(vif.rom_address), 15839);
      end
    end
    vif.run_req = 1'b0;
    do_tick();
    chk("stop_frame_sel", int'(vif.frame_sel), 0);
    chk("stop_running",   int'(vif.running),   0);

    // Sprite hanging off the bottom-right corner.
    vif.hero_x = 10'd620;
    vif.hero_y = 10'd470;
    do_tick();
    pix(10'd639, 10'd479, 1'b1, 1'b0);
    chk("corner_hit",  int'(vif.sprite_hit),  1);
    chk("corner_addr", int'(vif.rom_address), 379);
    pix(10'd639, 10'd479, 1'b1, 1'b1);
    chk("corner_mirror_addr", int'(vif.rom_address), 380);
    pix(10'd0, 10'd0, 1'b1, 1'b0);
    chk("corner_nowrap_hit", int'(vif.sprite_hit), 0);

    // Reset coinciding with frame_tick in the middle of the run animation.
    vif.hero_x  = 10'd100;
    vif.hero_y  = 10'd200;
    vif.run_req = 1'b1;
    for (int k = 0; k < 11; k++) do_tick();
    chk("pre_reset_frame_sel", int'(vif.frame_sel), 3);
    vif.hero_x     = 10'd50;
    vif.hero_y     = 10'd60;
    reset          = 1'b1;
    vif.frame_tick = 1'b1;
    step();
    chk("rst_tick_frame_sel", int'(vif.frame_sel), 0);
    chk("rst_tick_running",   int'(vif.running),   0);
    chk("rst_tick_hx",        int'(dut.hx_q),      0);
    chk("rst_tick_hy",        int'(dut.hy_q),      0);
    reset          = 1'b0;
    vif.frame_tick = 1'b0;
    vif.run_req    = 1'b0;
    step();

    // First tick after reset latches normally.
    do_tick();
    chk("post_rst_hx", int'(dut.hx_q), 50);
    pix(10'd50, 10'd60, 1'b1, 1'b0);
    chk("post_rst_hit",  int'(vif.sprite_hit),  1);
    chk("post_rst_addr", int'(vif.rom_address), 0);

    vif.blank = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
